// File: rtl/alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_sequencer_if
// Bundles the instruction request and the datapath control strobes of the
// ALU sequencer.
//   start, instr            : instruction source -> sequencer
//   Rin, Rout               : one-hot register write / bus-drive enables
//   ext                     : external data drives the bus
//   Ain, Gin, Gout, ALUcont : ALU A-latch load, G-latch load, G drive, FN
//   busy, done              : sequencer status
// master = instruction source, slave = sequencer.
// ---------------------------------------------------------------------------
interface alu_sequencer_if #(
    parameter int W    = 10,
    parameter int NREG = 4
);
    logic            start;
    logic [W-1:0]    instr;
    logic [NREG-1:0] Rin;
    logic [NREG-1:0] Rout;
    logic            ext;
    logic            Ain;
    logic            Gin;
    logic            Gout;
    logic [3:0]      ALUcont;
    logic            busy;
    logic            done;

    modport master (
        output start, instr,
        input  Rin, Rout, ext, Ain, Gin, Gout, ALUcont, busy, done
    );

    modport slave (
        input  start, instr,
        output Rin, Rout, ext, Ain, Gin, Gout, ALUcont, busy, done
    );
endinterface

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
// Control FSM for the 10-bit processor. Latches an instruction on start and
// steps the register file and multi-stage ALU through T1..T3.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_sequencer_if.slave (start/instr in, control strobes out)
// Instruction layout: [9:6] op, [5:4] Rx, [3:2] Ry, [1:0] ignored.
// op 0000 LOAD and 0001 COPY finish in T1; every other op is a 3-step ALU op.
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int W    = 10,
    parameter int NREG = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    ir_q, ir_d;

    logic [3:0]      op;
    logic [RW-1:0]   rx;
    logic [RW-1:0]   ry;
    logic [NREG-1:0] rx_oh;
    logic [NREG-1:0] ry_oh;
    logic            is_load;
    logic            is_copy;
    logic            final_step;
    logic            accept;
    logic            ir_unused;

    assign op        = ir_q[W-1:W-4];
    assign rx        = ir_q[W-5:W-6];
    assign ry        = ir_q[W-7:W-8];
    assign ir_unused = ^ir_q[1:0];

    assign is_load = (op == 4'b0000);
    assign is_copy = (op == 4'b0001);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
            assign rx_oh[gi] = (rx == RW'(gi));
            assign ry_oh[gi] = (ry == RW'(gi));
        end
    endgenerate

    // The last step of an instruction may accept the next one, which gives
    // back-to-back execution with no IDLE cycle in between.
    assign final_step = ((state_q == T1) && (is_load || is_copy)) || (state_q == T3);
    assign accept     = bus.start && ((state_q == IDLE) || final_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (accept) begin
            state_d = T1;
            ir_d    = bus.instr;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                T1:      state_d = (is_load || is_copy) ? IDLE : T2;
                T2:      state_d = T3;
                T3:      state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs depend only on (state, IR); IDLE leaves every strobe low, so an
    // asynchronous reset clears them immediately.
    always_comb begin
        bus.Rin     = '0;
        bus.Rout    = '0;
        bus.ext     = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.Gout    = 1'b0;
        bus.ALUcont = 4'b0000;
        bus.busy    = (state_q != IDLE);
        bus.done    = 1'b0;
        unique case (state_q)
            IDLE: ;
            T1: begin
                if (is_load) begin
                    bus.ext  = 1'b1;
                    bus.Rin  = rx_oh;
                    bus.done = 1'b1;
                end else if (is_copy) begin
                    bus.Rout = ry_oh;
                    bus.Rin  = rx_oh;
                    bus.done = 1'b1;
                end else begin
                    bus.Rout = rx_oh;
                    bus.Ain  = 1'b1;
                end
            end
            T2: begin
                bus.Rout    = ry_oh;
                bus.Gin     = 1'b1;
                bus.ALUcont = op;
            end
            T3: begin
                bus.Gout = 1'b1;
                bus.Rin  = rx_oh;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
